// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable clock divider. Each channel derives a divided
// clock (used as an enable for PWM, sampling and serial timebases) from
// clk_in, with a runtime-programmable period and high time, a run enable and
// a one-cycle period-start tick.
//
// Configuration writes land in per-channel shadow registers and are moved
// into the active registers only on the last cycle of a period, or at once
// while the channel is disabled. A ratio change therefore never produces a
// runt pulse: every period runs entirely with one set of values.
//
// Parameters
//   CHANNELS  number of divider channels (1..16)
//   CNT_W     width of counters and configuration values
//   DEF_DIV   reset period of every channel, in clk_in cycles
//   DEF_HIGH  reset high time of every channel, in clk_in cycles
//   SEL_W     width of cfg_sel (2**SEL_W >= CHANNELS)
//
// Ports
//   clk_in    in   system clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   per-channel run enable, level-sensitive
//   cfg_we    in   one-cycle configuration write strobe
//   cfg_sel   in   channel addressed by the write
//   cfg_div   in   requested period (0 and 1 are stored as 2)
//   cfg_high  in   requested high time (0 = constant low, >= period = high)
//   clk_out   out  registered divided clocks
//   tick      out  registered one-cycle pulse at each period start
//   pending   out  shadow written but not yet applied
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 10,
    parameter int DEF_HIGH = 5,
    parameter int SEL_W    = 2
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(CHANNELS);

    // Writes addressed beyond the last channel are dropped. The extra bit
    // keeps the comparison correct when CHANNELS == 2**SEL_W.
    logic             w_sel_ok;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_sel_ok      = ({1'b0, cfg_sel} < SEL_LIM);
    // A period of 0 or 1 cannot hold a high and a low phase, so it becomes 2.
    assign w_div_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div_a;
        logic [CNT_W-1:0] r_high_a;
        logic [CNT_W-1:0] r_div_s;
        logic [CNT_W-1:0] r_high_s;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;

        logic             w_wr;
        logic             w_last;
        logic             w_apply;

        assign w_wr    = cfg_we && w_sel_ok && (cfg_sel == SEL_W'(g));
        // div_a is never below 2, so div_a-1 cannot wrap.
        assign w_last  = (r_cnt >= r_div_a - ONE);
        // A disabled channel has no period in flight, so the shadow can be
        // taken over immediately.
        assign w_apply = r_pend && (!en[g] || w_last);

        // NOTE: every flop here is a small control register, not a memory, so
        // all of them are reset; the asynchronous reset clears the outputs
        // without waiting for a clock edge.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_div_a  <= DIV_RST;
                r_high_a <= HIGH_RST;
                r_div_s  <= DIV_RST;
                r_high_s <= HIGH_RST;
                r_pend   <= 1'b0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments make every decision below use
                // the values from before this edge, which is what gives the
                // "apply takes the old shadow, shadow takes the new write"
                // behaviour when both happen on the same edge.
                if (en[g]) begin
                    // high_a = 0 never matches (constant low); high_a >= div_a
                    // always matches (constant high).
                    r_clk  <= (r_cnt < r_high_a);
                    r_tick <= (r_cnt == '0);
                    r_cnt  <= w_last ? '0 : r_cnt + ONE;
                end else begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_cnt  <= '0;
                end

                if (w_apply) begin
                    r_div_a  <= r_div_s;
                    r_high_a <= r_high_s;
                end

                if (w_wr) begin
                    r_div_s  <= w_div_clamped;
                    r_high_s <= cfg_high;
                end

                // A write on the apply edge keeps the flag set so the newer
                // shadow goes out at the following boundary.
                if (w_wr) begin
                    r_pend <= 1'b1;
                end else if (w_apply) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign pending[g] = r_pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Directed bench for clk_div_multi, built with three channels so that a write
// to cfg_sel = 3 addresses a non-existent channel. Inputs change 1 ns after a
// rising edge; outputs are read at the same point. Iteration k of each loop
// looks at the outputs produced by edge E_k, where E_0 is the first edge that
// samples the new enable.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int CH = 3;

    logic          clk_in;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [15:0]   cfg_div;
    logic [15:0]   cfg_high;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(
        .CHANNELS (CH),
        .CNT_W    (16),
        .DEF_DIV  (10),
        .DEF_HIGH (5),
        .SEL_W    (2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] d, input logic [15:0] h);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_div  = d;
        cfg_high = h;
    endtask

    task automatic wr_idle();
        cfg_we   = 1'b0;
        cfg_sel  = '0;
        cfg_div  = '0;
        cfg_high = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = '0;
        wr_idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [CH-1:0] e_clk,
                              input logic [CH-1:0] e_tick, input logic [CH-1:0] e_pend);
        check({tag, " clk"},  32'(clk_out), 32'(e_clk));
        check({tag, " tick"}, 32'(tick),    32'(e_tick));
        check({tag, " pend"}, 32'(pending), 32'(e_pend));
    endtask

    initial begin
        logic          c;
        logic          t;
        logic          p;
        int            m;

        do_reset();
        step();
        check_outs("reset", 3'b000, 3'b000, 3'b000);

        // Test 1: channel 0 with defaults, 5 high / 5 low, tick on the rise.
        en = 3'b001;
        for (int k = 0; k < 22; k++) begin
            step();
            c = ((k % 10) < 5);
            t = ((k % 10) == 0);
            check_outs("t1", {2'b00, c}, {2'b00, t}, 3'b000);
        end

        // Test 2: reprogram channel 1 mid-period (sampled at cnt = 3).
        do_reset();
        en = 3'b010;
        for (int k = 0; k < 22; k++) begin
            step();
            if (k < 10) begin
                c = (k < 5);
                t = (k == 0);
            end else begin
                c = (((k - 10) % 4) < 1);
                t = (((k - 10) % 4) == 0);
            end
            p = (k >= 3 && k <= 8);
            check_outs("t2", {1'b0, c, 1'b0}, {1'b0, t, 1'b0}, {1'b0, p, 1'b0});
            if (k == 2) wr(2'd1, 16'd4, 16'd1);
            else        wr_idle();
        end

        // Test 3: channel 2 clamp, constant low, constant high.
        do_reset();
        wr(2'd2, 16'd1, 16'd1);
        step();
        wr_idle();
        check("t3 pend set", 32'(pending), 32'(3'b100));
        step();
        check("t3 pend disabled apply", 32'(pending), 32'(3'b000));
        en = 3'b100;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k <= 9)       c = ((k % 2) == 0);
            else if (k <= 17) c = 1'b0;
            else              c = 1'b1;
            if (k <= 17) t = ((k % 2) == 0);
            else         t = (((k - 18) % 6) == 0);
            p = (k == 8 || k == 16);
            check_outs("t3", {c, 2'b00}, {t, 2'b00}, {p, 2'b00});
            if (k == 7)       wr(2'd2, 16'd2, 16'd0);
            else if (k == 15) wr(2'd2, 16'd6, 16'd7);
            else              wr_idle();
        end

        // Test 4: write on the last-cycle edge, then an out-of-range write.
        do_reset();
        en = 3'b001;
        for (int k = 0; k < 30; k++) begin
            step();
            if (k < 10) begin
                c = (k < 5);
                t = (k == 0);
            end else if (k < 14) begin
                c = ((k - 10) < 2);
                t = (k == 10);
            end else begin
                m = (k - 14) % 6;
                c = (m < 3);
                t = (m == 0);
            end
            p = (k >= 3 && k <= 12);
            check_outs("t4", {2'b00, c}, {2'b00, t}, {2'b00, p});
            if (k == 2)       wr(2'd0, 16'd4, 16'd2);
            else if (k == 8)  wr(2'd0, 16'd6, 16'd3);
            else if (k == 20) wr(2'd3, 16'd2, 16'd1);
            else              wr_idle();
        end

        // Test 5: drop en[0] at cnt = 2 with a write pending, then re-enable.
        do_reset();
        en = 3'b001;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 0) begin
                c = 1'b1; t = 1'b1; p = 1'b0;
            end else if (k == 1) begin
                c = 1'b1; t = 1'b0; p = 1'b1;
            end else if (k < 4) begin
                c = 1'b0; t = 1'b0; p = 1'b0;
            end else begin
                m = (k - 4) % 4;
                c = (m < 3);
                t = (m == 0);
                p = 1'b0;
            end
            check_outs("t5", {2'b00, c}, {2'b00, t}, {2'b00, p});
            if (k == 0) begin
                wr(2'd0, 16'd4, 16'd3);
            end else if (k == 1) begin
                wr_idle();
                en = 3'b000;
            end else if (k == 3) begin
                en = 3'b001;
            end
        end

        // Test 6: asynchronous reset mid-period, then an in-phase restart.
        do_reset();
        en = 3'b111;
        for (int k = 0; k < 4; k++) step();
        check("t6 before reset clk", 32'(clk_out), 32'(3'b111));
        rst_n = 1'b0;
        #1;
        check_outs("t6 async", 3'b000, 3'b000, 3'b000);
        step();
        check_outs("t6 held", 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            c = ((k % 10) < 5);
            t = ((k % 10) == 0);
            check_outs("t6", {3{c}}, {3{t}}, 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider for the carADS FPGA firmware. It derives up to CHANNELS independent divided clocks (enables for PWM, sampling and serial timebases) from clk_in. Each channel has a runtime-programmable period and high time, a per-channel enable and a period-start tick. Configuration writes are staged in shadow registers and applied only at a period boundary, so a ratio change never produces a runt pulse.

## Interface
- CHANNELS, 4, number of divider channels (1..16)
- CNT_W, 16, width of counters and configuration values
- DEF_DIV, 10, reset period of every channel in clk_in cycles
- DEF_HIGH, 5, reset high time of every channel in clk_in cycles
- SEL_W, 2, width of cfg_sel; must satisfy 2^SEL_W >= CHANNELS

- clk_in  input  1  system clock; all logic rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  CHANNELS  per-channel run enable, level-sensitive
- cfg_we  input  1  configuration write strobe, one cycle
- cfg_sel  input  SEL_W  channel addressed by the write
- cfg_div  input  CNT_W  requested period in clk_in cycles
- cfg_high  input  CNT_W  requested high time in clk_in cycles
- clk_out  output  CHANNELS  divided clocks, registered
- tick  output  CHANNELS  one-cycle pulse at each period start, registered
- pending  output  CHANNELS  shadow value written but not yet applied

## Operation
- Per channel state: counter cnt, active div_a/high_a, shadow div_s/high_s, pending flag.
- Reset: cnt=0, div_a=div_s=DEF_DIV, high_a=high_s=DEF_HIGH, pending=0, clk_out=0, tick=0.
- Write: on an edge with cfg_we=1 and cfg_sel<CHANNELS: div_s[sel]<=cfg_div, high_s[sel]<=cfg_high, pending[sel]<=1. Writes with cfg_sel>=CHANNELS are ignored.
- Clamp at write: a cfg_div value of 0 or 1 is stored as 2.
- High time: high_a=0 gives constant low. high_a>=div_a gives constant high. The tick still runs in both cases.
- Running (en=1) at each edge, with c = current cnt:
  - clk_out <= (c < high_a)
  - tick <= (c == 0)
  - cnt <= (c >= div_a-1) ? 0 : c+1
- Apply: on the edge where c >= div_a-1 (last cycle of a period) and pending=1, div_a/high_a <= shadow and pending <= 0. The next period runs entirely with the new values.
- Write and apply on the same edge for the same channel:
  - apply takes the old shadow value;
  - the shadow takes the new write;
  - pending stays 1, so the new value applies at the following boundary.
- Disabled (en=0) at each edge: cnt<=0, clk_out<=0, tick<=0. A pending shadow is applied immediately (pending<=0). Disabling mid-period truncates the period.
- Channels are fully independent. Writes to one channel never disturb another.

## Timing
- Outputs are registered. clk_out and tick reflect the counter value present before the edge.
- Enable latency: if en rises before edge E0, then at E0 clk_out<=(high_a>0) and tick<=1, so both are visible one cycle after en rises.
- Period is exactly div_a cycles and high time is exactly min(high_a, div_a) cycles. The pattern is phase-continuous across periods.
- Write-to-effect: the new values take effect from the first edge of the period after the boundary that follows the write. Worst case is div_a cycles plus one cycle.
- Asynchronous reset mid-period forces every output low immediately and restores the defaults.
- Counter comparisons are unsigned CNT_W-bit. Counters never exceed div_a-1, except when a smaller div_a is loaded while disabled; in that case cnt is 0 anyway.

## Test plan
- Reset, then en=4'b0001 with defaults -> clk_out[0] repeats 5 high / 5 low, tick[0] pulses every 10 cycles coincident with the clk_out[0] rise; other channels stay 0.
- Channel 1 running div=10/high=5; write sel=1, div=4, high=1 at cnt=3 -> the current 10-cycle period completes unchanged; next periods are 1 high / 3 low; pending[1] is high from the write until the boundary.
- Write div=1, high=1 to channel 2, en[2]=1 -> stored as div=2, clk_out[2] toggles every cycle (1 high / 1 low); write high=0 -> constant low with tick every 2 cycles; write high=7, div=6 -> constant high.
- Write to channel 0 on exactly the last-cycle edge -> the previous shadow applies, pending[0] stays 1, and the new value applies one period later; a write with cfg_sel=3 while CHANNELS=3 changes nothing.
- Drop en[0] at cnt=2 with a write pending -> the next edge gives clk_out=0, tick=0, pending=0; re-enable -> the first period uses the new values starting with tick=1.
- Assert rst_n low mid-period on all channels -> all outputs go to 0 immediately; after release with en=all ones, all channels restart in phase with DEF_DIV/DEF_HIGH.
